// File: rtl/pipe_stage_skid_reg_pkg.sv
// rtl/pipe_stage_skid_reg_pkg.sv - control-word layout and shared constants for pipeline stage registers
package pipe_stage_skid_reg_pkg;

  localparam int PIPE_CTRL_W = 24;

  // Control-word bit positions; any set enable bit marks a live instruction.
  localparam int RF_WENA      = 0;
  localparam int HI_WENA      = 1;
  localparam int LO_WENA      = 2;
  localparam int DMEM_WENA    = 3;
  localparam int DMEM_ENA     = 4;
  localparam int SEL_LSB      = 5;
  localparam int SEL_W        = 14;
  localparam int RF_WADDR_LSB = 19;
  localparam int RF_WADDR_W   = 5;

  localparam logic RST_ENABLED   = 1'b1;
  localparam logic WRITE_ENABLED = 1'b1;

  localparam logic [PIPE_CTRL_W-1:0] BUBBLE = '0;

  function automatic logic is_bubble(input logic [PIPE_CTRL_W-1:0] ctrl);
    return ctrl == BUBBLE;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_slot.sv
// rtl/pipe_stage_skid_reg_slot.sv - one valid+ctrl+data slot with load and clear-to-bubble
module pipe_slot_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int DATA_W = 384,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Clear wins over load so a flush always kills a concurrent transfer; data is left alone.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - generic valid/ready pipeline stage with optional two-entry skid buffer
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int DATA_W = 384,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              accept, issue;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data, main_data_in;
  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  // A pending skid entry always drains into main first, which keeps FIFO order.
  assign main_load    = (skid_valid & issue) | (accept & (~out_valid | issue));
  assign main_clear   = flush | (issue & ~skid_valid & ~accept);
  assign skid_load    = accept & out_valid & ~issue;
  assign skid_clear   = flush | (issue & skid_valid);
  assign main_data_in = skid_valid ? skid_data : in_data;
  assign main_ctrl_in = skid_valid ? skid_ctrl : in_ctrl;

  pipe_slot_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_data_in),
    .ctrl_i  (main_ctrl_in),
    .valid_o (out_valid),
    .data_o  (out_data),
    .ctrl_o  (out_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
      );
      // Ready comes straight from a flop, cutting the stall path through the pipe.
      assign in_ready = ~skid_valid;
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      assign in_ready   = ~out_valid | out_ready;
    end
  endgenerate

  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - directed and scoreboarded checks of pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

  localparam int DW = 384;
  localparam int CW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_in_data = '0, a_out_data;
  logic [CW-1:0] a_in_ctrl = '0, a_out_ctrl;
  logic [1:0]    a_occ;

  logic          b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_in_data = '0, b_out_data;
  logic [CW-1:0] b_in_ctrl = '0, b_out_ctrl;
  logic [1:0]    b_occ;

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ)
  );

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    return {12{8'hA5, c}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_drive(input logic v, input logic [CW-1:0] c);
    a_in_valid = v;
    a_in_ctrl  = c;
    a_in_data  = mk_data(c);
  endtask

  task automatic b_drive(input logic v, input logic [CW-1:0] c);
    b_in_valid = v;
    b_in_ctrl  = c;
    b_in_data  = mk_data(c);
  endtask

  logic [CW-1:0] q[$];
  logic [CW-1:0] seq;
  logic          held;

  initial begin
    @(negedge clk);
    #1;
    check("rst_valid", DW'(a_out_valid), DW'(0));
    check("rst_occ", DW'(a_occ), DW'(0));

    // Asynchronous reset pulse between clock edges.
    @(negedge clk);
    rst = 1'b0;
    a_drive(1'b1, 24'h9);
    @(negedge clk);
    a_drive(1'b0, 24'h0);
    check("pre_rst_ctrl", DW'(a_out_ctrl), DW'(24'h9));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", DW'(a_out_valid), DW'(0));
    check("arst_ctrl", DW'(a_out_ctrl), DW'(0));
    check("arst_data", a_out_data, DW'(0));
    check("arst_occ", DW'(a_occ), DW'(0));
    check("arst_in_ready", DW'(a_in_ready), DW'(1));
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate.
    a_out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k > 1) begin
        check("stream_ctrl", DW'(a_out_ctrl), DW'(k - 1));
        check("stream_occ", DW'(a_occ), DW'(1));
      end
      a_drive(1'b1, CW'(k));
    end
    @(negedge clk);
    check("stream_last", DW'(a_out_ctrl), DW'(8));
    a_drive(1'b0, 24'h0);
    @(negedge clk);
    check("stream_drained", DW'(a_out_valid), DW'(0));

    // Back-pressure fills main then skid, then drains in order.
    a_out_ready = 1'b0;
    @(negedge clk);
    a_drive(1'b1, 24'h11);
    @(negedge clk);
    check("bp_main", DW'(a_out_ctrl), DW'(24'h11));
    check("bp_occ1", DW'(a_occ), DW'(1));
    a_drive(1'b1, 24'h22);
    @(negedge clk);
    check("bp_occ2", DW'(a_occ), DW'(2));
    a_drive(1'b1, 24'h33);
    #1;
    check("bp_in_ready", DW'(a_in_ready), DW'(0));
    @(negedge clk);
    check("bp_hold_ctrl", DW'(a_out_ctrl), DW'(24'h11));
    check("bp_hold_occ", DW'(a_occ), DW'(2));
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_out22", DW'(a_out_ctrl), DW'(24'h22));
    check("bp_data22", a_out_data, mk_data(24'h22));
    check("bp_ready_back", DW'(a_in_ready), DW'(1));
    @(negedge clk);
    check("bp_out33", DW'(a_out_ctrl), DW'(24'h33));
    check("bp_occ_after", DW'(a_occ), DW'(1));
    a_drive(1'b0, 24'h0);
    @(negedge clk);
    check("bp_empty", DW'(a_out_valid), DW'(0));

    // Flush with both entries full and an offered input.
    a_out_ready = 1'b0;
    @(negedge clk);
    a_drive(1'b1, 24'h55);
    @(negedge clk);
    a_drive(1'b1, 24'h66);
    @(negedge clk);
    check("fl_occ2", DW'(a_occ), DW'(2));
    a_flush = 1'b1;
    a_drive(1'b1, 24'h44);
    @(negedge clk);
    a_flush = 1'b0;
    a_drive(1'b0, 24'h0);
    check("fl_valid", DW'(a_out_valid), DW'(0));
    check("fl_ctrl", DW'(a_out_ctrl), DW'(0));
    check("fl_occ", DW'(a_occ), DW'(0));
    check("fl_data_hold", a_out_data, mk_data(24'h55));
    a_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fl_no44", DW'(a_out_valid), DW'(0));
    end

    // Flush discarding a concurrent accept at occupancy 1.
    a_out_ready = 1'b0;
    @(negedge clk);
    a_drive(1'b1, 24'h70);
    @(negedge clk);
    check("fl1_occ", DW'(a_occ), DW'(1));
    a_flush = 1'b1;
    a_drive(1'b1, 24'h71);
    #1;
    check("fl1_in_ready", DW'(a_in_ready), DW'(1));
    @(negedge clk);
    a_flush = 1'b0;
    a_drive(1'b0, 24'h0);
    check("fl1_occ0", DW'(a_occ), DW'(0));
    check("fl1_ctrl", DW'(a_out_ctrl), DW'(0));

    // SKID=0: combinational ready follows out_ready.
    @(negedge clk);
    b_drive(1'b1, 24'h77);
    @(negedge clk);
    check("s0_valid", DW'(b_out_valid), DW'(1));
    b_drive(1'b1, 24'h78);
    #1;
    check("s0_ready_lo", DW'(b_in_ready), DW'(0));
    b_out_ready = 1'b1;
    #1;
    check("s0_ready_hi", DW'(b_in_ready), DW'(1));
    @(negedge clk);
    check("s0_ctrl78", DW'(b_out_ctrl), DW'(24'h78));
    check("s0_occ1", DW'(b_occ), DW'(1));
    b_drive(1'b0, 24'h0);
    @(negedge clk);
    check("s0_empty", DW'(b_out_valid), DW'(0));
    check("s0_occ0", DW'(b_occ), DW'(0));

    // Randomised traffic against a queue scoreboard.
    seq  = 24'h100;
    held = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if (!held) begin
        if ($urandom_range(0, 9) < 7) begin
          seq = seq + 24'h1;
          a_drive(1'b1, seq);
        end else begin
          a_drive(1'b0, 24'h0);
        end
      end
      a_out_ready = ($urandom_range(0, 9) < 6);
      a_flush     = ($urandom_range(0, 31) == 0);
      #1;
      if (!a_out_valid) check("rnd_bubble", DW'(a_out_ctrl), DW'(0));
      check("rnd_occ", DW'(a_occ), DW'(q.size()));
      if (a_out_valid && a_out_ready && q.size() > 0) begin
        check("rnd_order", DW'(a_out_ctrl), DW'(q[0]));
        check("rnd_data", a_out_data, mk_data(q[0]));
        void'(q.pop_front());
      end
      if (a_in_valid && a_in_ready) q.push_back(a_in_ctrl);
      if (a_flush) q.delete();
      held = a_in_valid && !a_in_ready && !a_flush;
    end
    @(negedge clk);
    a_flush = 1'b0;
    a_drive(1'b0, 24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
